// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller (master) and memory (slave).
// Single outstanding request; ack is a one-cycle data-valid pulse.
interface ifetch_ctrl_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_rdata_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: direct-mapped line buffer in front of a multi-cycle
// instruction memory, with PC hold on miss and flush handling while a read is in flight.
module ifetch_ctrl #(
  parameter int LINES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      pc_i,
  input  logic             flush_i,
  input  logic             id_stall_i,
  output logic [31:0]      inst_o,
  output logic             inst_valid_o,
  output logic             pc_hold_o,
  ifetch_ctrl_if.master    mem,
  output logic [CNT_W-1:0] miss_cnt_o
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t           r_state, w_next;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];
  logic [31:0]      r_addr;
  logic             r_req;
  logic [CNT_W-1:0] r_cnt;

  logic [IDX_W-1:0] w_idx, w_fidx;
  logic [TAG_W-1:0] w_tag, w_ftag;
  logic             w_hit, w_issue, w_done, w_fill;

  assign w_idx  = pc_i[IDX_W+1:2];
  assign w_tag  = pc_i[31:IDX_W+2];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // Fill goes to the line of the address actually requested, not the current PC.
  assign w_fidx = r_addr[IDX_W+1:2];
  assign w_ftag = r_addr[31:IDX_W+2];

  assign mem.mem_req_o  = r_req;
  assign mem.mem_addr_o = r_addr;
  assign miss_cnt_o     = r_cnt;

  always_comb begin
    w_next       = r_state;
    inst_o       = '0;
    inst_valid_o = 1'b0;
    pc_hold_o    = 1'b0;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    w_fill       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i && !flush_i) begin
          if (w_hit) begin
            inst_o       = r_data[w_idx];
            inst_valid_o = 1'b1;
            pc_hold_o    = id_stall_i;
          end else begin
            pc_hold_o = 1'b1;
            w_issue   = 1'b1;
            w_next    = WAIT;
          end
        end
      end
      WAIT: begin
        // Releasing the hold on flush lets the PC take the branch target now.
        pc_hold_o = !flush_i;
        if (mem.mem_ack_i) begin
          w_done = 1'b1;
          w_fill = !flush_i;
          w_next = IDLE;
        end else if (flush_i) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        pc_hold_o = !flush_i;
        if (mem.mem_ack_i) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_addr <= pc_i & ~32'h3;
        r_req  <= 1'b1;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done) r_req <= 1'b0;
      if (w_fill) begin
        r_valid[w_fidx] <= 1'b1;
        r_tag[w_fidx]   <= w_ftag;
        r_data[w_fidx]  <= mem.mem_rdata_i;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: vector table for miss/hit/conflict, hand sequences for flush and reset corners.
module tb_ifetch_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_n_i, start_i, flush_i, id_stall_i;
  logic [31:0] pc_i;
  logic [31:0] inst_o, inst2;
  logic        inst_valid_o, pc_hold_o, v2, h2;
  logic [15:0] miss_cnt_o;
  logic [1:0]  cnt2;

  ifetch_ctrl_if mem();
  ifetch_ctrl_if mem2();
  assign mem2.mem_ack_i   = mem.mem_ack_i;
  assign mem2.mem_rdata_i = mem.mem_rdata_i;

  ifetch_ctrl #(.LINES(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .pc_i(pc_i),
    .flush_i(flush_i), .id_stall_i(id_stall_i), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o), .pc_hold_o(pc_hold_o), .mem(mem.master),
    .miss_cnt_o(miss_cnt_o));

  ifetch_ctrl #(.LINES(4), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .pc_i(pc_i),
    .flush_i(flush_i), .id_stall_i(id_stall_i), .inst_o(inst2),
    .inst_valid_o(v2), .pc_hold_o(h2), .mem(mem2.master),
    .miss_cnt_o(cnt2));

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst_n, start;
    logic [31:0] pc;
    logic        flush, stall, ack;
    logic [31:0] rdata;
    logic [31:0] e_inst;
    logic        e_v, e_h, e_req;
    logic [31:0] e_addr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rn, logic s, logic [31:0] pc, logic f, logic st, logic a,
                              logic [31:0] rd, logic [31:0] ei, logic ev, logic eh, logic er,
                              logic [31:0] ea, logic [15:0] ec);
    vec_t v;
    v.rst_n = rn; v.start = s; v.pc = pc; v.flush = f; v.stall = st; v.ack = a; v.rdata = rd;
    v.e_inst = ei; v.e_v = ev; v.e_h = eh; v.e_req = er; v.e_addr = ea; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] pc, input logic f, input logic a,
                       input logic [31:0] rd);
    start_i = s; pc_i = pc; flush_i = f; id_stall_i = 1'b0;
    mem.mem_ack_i = a; mem.mem_rdata_i = rd;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Full miss: issue, one-cycle ack, then the refetch must hit with the returned word.
  task automatic do_miss(input logic [31:0] pc, input logic [31:0] d);
    drive(1'b1, pc, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("miss_hold", {inst_valid_o, pc_hold_o}, {1'b0, 1'b1});
    tick();
    drive(1'b1, pc, 1'b0, 1'b1, d);
    @(negedge clk_i); chk("miss_req", {mem.mem_req_o, mem.mem_addr_o}, {1'b1, pc & ~32'h3});
    tick();
    drive(1'b1, pc, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("fill_hit", {inst_valid_o, inst_o}, {1'b1, d});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  localparam logic [31:0] D = 32'h20010005;
  localparam logic [31:0] A = 32'hAAAA0010;

  initial begin
    rst_n_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    //         rn s  pc     f  st a  rdata   inst v  h  req addr   cnt
    vt.push_back(mk(0, 0, 32'h00, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h00, 0));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h00, 0));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h00, 1));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h00, 1));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h00, 1));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 1, D,     32'h0, 0, 1, 1, 32'h00, 1));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 0, 32'h0, D,     1, 0, 0, 32'h00, 1));
    vt.push_back(mk(1, 1, 32'h00, 0, 1, 0, 32'h0, D,     1, 1, 0, 32'h00, 1));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 0, 32'h0, D,     1, 0, 0, 32'h00, 1));
    vt.push_back(mk(1, 1, 32'h10, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h00, 1));
    vt.push_back(mk(1, 1, 32'h10, 0, 0, 1, A,     32'h0, 0, 1, 1, 32'h10, 2));
    vt.push_back(mk(1, 1, 32'h10, 0, 0, 0, 32'h0, A,     1, 0, 0, 32'h10, 2));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h10, 2));
    vt.push_back(mk(1, 1, 32'h00, 0, 0, 1, D,     32'h0, 0, 1, 1, 32'h00, 3));
    vt.push_back(mk(1, 1, 32'h02, 0, 0, 0, 32'h0, D,     1, 0, 0, 32'h00, 3));
    vt.push_back(mk(1, 1, 32'h40, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h00, 3));
    vt.push_back(mk(1, 0, 32'h00, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h00, 3));

    foreach (vt[i]) begin
      rst_n_i = vt[i].rst_n; start_i = vt[i].start; pc_i = vt[i].pc; flush_i = vt[i].flush;
      id_stall_i = vt[i].stall; mem.mem_ack_i = vt[i].ack; mem.mem_rdata_i = vt[i].rdata;
      @(negedge clk_i);
      chk($sformatf("vec%0d", i),
          {inst_o, inst_valid_o, pc_hold_o, mem.mem_req_o, mem.mem_addr_o, miss_cnt_o},
          {vt[i].e_inst, vt[i].e_v, vt[i].e_h, vt[i].e_req, vt[i].e_addr, vt[i].e_cnt});
      tick();
    end

    // Flush one cycle before the ack: hold released, then DRAIN discards the data.
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("w_miss8_hold", pc_hold_o, 1'b1);
    tick();
    @(negedge clk_i); chk("w_wait_req", {mem.mem_req_o, mem.mem_addr_o, pc_hold_o}, {1'b1, 32'h8, 1'b1});
    tick();
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i); chk("w_flush_hold", {pc_hold_o, inst_valid_o}, {1'b0, 1'b0});
    tick();
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("drain_hold", {pc_hold_o, mem.mem_req_o, mem.mem_addr_o}, {1'b1, 1'b1, 32'h8});
    tick();
    drive(1'b1, 32'h40, 1'b0, 1'b1, 32'hDEAD0008);
    @(negedge clk_i); chk("drain_ack", {pc_hold_o, inst_valid_o}, {1'b1, 1'b0});
    tick();
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("tgt_miss", {mem.mem_req_o, pc_hold_o}, {1'b0, 1'b1});
    tick();
    drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h11110040);
    @(negedge clk_i); chk("tgt_req", {mem.mem_req_o, mem.mem_addr_o, miss_cnt_o}, {1'b1, 32'h40, 16'd5});
    tick();
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("tgt_hit", {inst_valid_o, inst_o}, {1'b1, 32'h11110040});
    tick();
    do_miss(32'h8, 32'h22220008);

    // Flush coincident with the ack: no fill, straight back to IDLE.
    drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h14, 1'b1, 1'b1, 32'h33330014);
    @(negedge clk_i); chk("fa_hold", pc_hold_o, 1'b0);
    tick();
    drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("fa_idle_miss", {mem.mem_req_o, pc_hold_o}, {1'b0, 1'b1});
    tick();
    drive(1'b1, 32'h80, 1'b0, 1'b1, 32'h55550080);
    @(negedge clk_i); chk("fa_tgt_req", {mem.mem_req_o, mem.mem_addr_o}, {1'b1, 32'h80});
    tick();
    do_miss(32'h14, 32'h66660014);

    // Reset mid-WAIT, late ack ignored, then counter saturation.
    drive(1'b1, 32'h24, 1'b0, 1'b0, 32'h0);
    tick();
    rst_n_i = 1'b0; drive(1'b0, 32'h24, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("pre_rst_req", mem.mem_req_o, 1'b1);
    tick();
    rst_n_i = 1'b1; drive(1'b0, 32'h24, 1'b0, 1'b1, 32'h99999999);
    @(negedge clk_i);
    chk("rst_state", {mem.mem_req_o, mem.mem_addr_o, miss_cnt_o, cnt2, pc_hold_o, inst_valid_o},
        {1'b0, 32'h0, 16'd0, 2'd0, 1'b0, 1'b0});
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); chk("rst_lines_inv", {inst_valid_o, pc_hold_o, mem.mem_req_o}, {1'b0, 1'b1, 1'b0});
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h44440000);
    @(negedge clk_i); chk("rst_req0", {mem.mem_req_o, mem.mem_addr_o}, {1'b1, 32'h0});
    tick();
    do_miss(32'h100, 32'h0A000100);
    do_miss(32'h104, 32'h0A000104);
    do_miss(32'h108, 32'h0A000108);
    do_miss(32'h10C, 32'h0A00010C);
    chk("cnt16", miss_cnt_o, 16'd5);
    chk("cnt2_sat", cnt2, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller between the PC register and a multi-cycle instruction memory.
- Consumes the PC value and returns the instruction to the IF/ID stage through a small direct-mapped line buffer.
- On a miss it issues a req/ack memory transaction and drives pc_hold_o back to the PC's PCWrite_i input (1 = hold PC) until the word arrives.
- Handles branch flushes, including flushes while a memory transaction is in flight.

Parameters:
- LINES, 4, number of buffer entries; power of 2, ≥2; index = pc[log2(LINES)+1:2].
- CNT_W, 16, width of the saturating miss counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- start_i  in  1  CPU run enable; 0 = no fetch activity.
- pc_i  in  32  fetch address from PC (pc_o).
- flush_i  in  1  branch/jump taken this cycle; current fetch is abandoned.
- id_stall_i  in  1  IF/ID not accepting (hazard hold).
- inst_o  out  32  fetched instruction.
- inst_valid_o  out  1  inst_o valid this cycle.
- pc_hold_o  out  1  to PC PCWrite_i; 1 = PC keeps its value.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  32  word-aligned read address.
- mem_ack_i  in  1  memory data valid (one-cycle pulse).
- mem_rdata_i  in  32  memory read data.
- miss_cnt_o  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (rst_n_i=0 at clock edge):
  - state=IDLE; all line valid bits=0; miss_cnt_o=0; mem_req_o=0; mem_addr_o=0.
  - Combinational outputs: inst_o=0, inst_valid_o=0, pc_hold_o=0.
  - Reset while WAIT/DRAIN: request dropped at that edge; any later ack is ignored.
- Address: aligned addr = {pc_i[31:2],2'b00}; pc_i[1:0] ignored. Each line stores valid, tag=pc[31:log2(LINES)+2], data.
- States: IDLE, WAIT, DRAIN.
- IDLE, start_i=0: inst_valid_o=0, pc_hold_o=0, no request.
- IDLE, start_i=1, flush_i=1: inst_valid_o=0, pc_hold_o=0 so PC loads the target; no request, no buffer lookup that cycle.
- IDLE, start_i=1, hit (line valid and tag match):
  - Same cycle, combinational: inst_o=line data, inst_valid_o=1, pc_hold_o=id_stall_i.
- IDLE, start_i=1, miss:
  - Same cycle: inst_valid_o=0, pc_hold_o=1.
  - At the edge: mem_addr_o<=aligned addr, mem_req_o<=1, miss_cnt_o+=1 (saturates at all-ones), state->WAIT.
- WAIT:
  - mem_req_o=1, mem_addr_o stable, pc_hold_o=1, inst_valid_o=0.
  - mem_ack_i=1: write line (valid=1, tag, mem_rdata_i), mem_req_o<=0, ->IDLE. The next cycle hits, so a miss delivers the instruction 2 cycles after the ack edge cycle... precisely: miss at T, req from T+1, ack at T+1+L, instruction at T+2+L.
- WAIT with flush_i=1:
  - Request cannot be withdrawn. pc_hold_o=0 that cycle so the PC takes the target.
  - If mem_ack_i=0: ->DRAIN.
  - If mem_ack_i=1 the same cycle: data discarded (no line write), mem_req_o<=0, ->IDLE.
- DRAIN:
  - mem_req_o=1, pc_hold_o=1, inst_valid_o=0.
  - On mem_ack_i: discard data, mem_req_o<=0, ->IDLE.
  - flush_i=1 in DRAIN: pc_hold_o=0 that cycle; otherwise same as DRAIN.
- General:
  - mem_ack_i is ignored when mem_req_o=0.
  - start_i is ignored in WAIT/DRAIN; the transaction completes.
  - flush_i never invalidates lines; instruction memory is static.
  - At most one outstanding request.

Test Plan:
1. Cold miss: reset; start_i=1, pc_i=0x0; memory acks after 3 cycles with 0x20010005.
   -> mem_req_o=1 with mem_addr_o=0x0 until the ack; pc_hold_o=1 through WAIT; the cycle after the ack, inst_o=0x20010005, inst_valid_o=1, pc_hold_o=0; miss_cnt_o=1.
2. Hit and stall: re-present pc_i=0x0 with id_stall_i=1, then 0.
   -> inst_valid_o=1 same cycle, no mem_req_o; pc_hold_o=1 then 0; miss_cnt_o unchanged.
3. Conflict, LINES=4: fetch 0x10 (index 0, new tag), then 0x0.
   -> both miss; miss_cnt_o +2; the second returns the 0x0 data from memory.
4. Flush in WAIT: miss on 0x8; flush_i=1 one cycle before the ack; pc_i goes to 0x40.
   -> pc_hold_o=0 in the flush cycle, then DRAIN with pc_hold_o=1; ack data not written (later fetch of 0x8 misses); then a new request to 0x40.
5. Flush coincident with ack in WAIT.
   -> no line write, ->IDLE, next cycle a request for the target address.
6. Reset mid-WAIT, then saturation (CNT_W=2):
   -> at the reset edge mem_req_o=0, lines invalid, miss_cnt_o=0; a late ack is ignored. Five distinct misses -> miss_cnt_o=3.
